// File: rtl/binary_intermediate_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : binary_intermediate_ctrl
// Description : Sequencer for the binary XNOR-popcount intermediate layer.
//               Fetches NUM_TOKENS binarised token vectors from the token
//               buffer. Issues each token to the datapath once per weight
//               block. Packs the returned per-block results into one word
//               per token and writes that word to the next-layer buffer.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk                 : clock
//   rst_n               : asynchronous active-low reset
//   start_i             : run request, honoured only when idle or done
//   in_rd_en_o          : token buffer read strobe
//   in_rd_addr_o        : token index to read
//   in_rd_data_i        : token read data, valid one cycle after the strobe
//   dp_data_in_o        : token vector presented to the datapath
//   dp_data_in_valid_o  : datapath issue strobe
//   dp_block_sel_o      : weight block select for the issued beat
//   dp_data_out_i       : datapath result
//   dp_data_out_valid_i : result strobe, one per issued beat, in order
//   out_wr_en_o         : output buffer write strobe
//   out_wr_addr_o       : token index written
//   out_wr_data_o       : packed result, block b at [b*OUT_W +: OUT_W]
//   busy_o              : run in progress
//   done_o              : run complete (level, held until next start)
//   err_o               : sticky protocol error
// ============================================================================
module binary_intermediate_ctrl #(
    parameter int NUM_TOKENS = 30,
    parameter int NUM_BLOCKS = 4,
    parameter int IN_W       = 64,
    parameter int OUT_W      = 16,
    parameter int SEL_W      = 2,
    parameter int AW         = 5
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        start_i,
    output logic                        in_rd_en_o,
    output logic [AW-1:0]               in_rd_addr_o,
    input  logic [IN_W-1:0]             in_rd_data_i,
    output logic [IN_W-1:0]             dp_data_in_o,
    output logic                        dp_data_in_valid_o,
    output logic [SEL_W-1:0]            dp_block_sel_o,
    input  logic [OUT_W-1:0]            dp_data_out_i,
    input  logic                        dp_data_out_valid_i,
    output logic                        out_wr_en_o,
    output logic [AW-1:0]               out_wr_addr_o,
    output logic [NUM_BLOCKS*OUT_W-1:0] out_wr_data_o,
    output logic                        busy_o,
    output logic                        done_o,
    output logic                        err_o
);

    localparam int              c_PACK_W   = NUM_BLOCKS * OUT_W;
    localparam int              c_OUTS_W   = $clog2(NUM_TOKENS * NUM_BLOCKS + 1);
    localparam logic [AW-1:0]    c_LAST_TOK = AW'(NUM_TOKENS - 1);
    localparam logic [SEL_W-1:0] c_LAST_BLK = SEL_W'(NUM_BLOCKS - 1);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FETCH = 3'd1,
        ST_LOAD  = 3'd2,
        ST_ISSUE = 3'd3,
        ST_DRAIN = 3'd4,
        ST_DONE  = 3'd5
    } state_e;

    state_e                state_q, state_d;
    logic [AW-1:0]         tok_q, tok_d;
    logic [SEL_W-1:0]      beat_q, beat_d;
    logic [IN_W-1:0]       hold_q, hold_d;
    logic [AW-1:0]         cap_tok_q, cap_tok_d;
    logic [SEL_W-1:0]      cap_blk_q, cap_blk_d;
    logic [c_PACK_W-1:0]   pack_q, pack_d;
    logic [c_OUTS_W-1:0]   outst_q, outst_d;

    logic                  in_rd_en_q, in_rd_en_d;
    logic [AW-1:0]         in_rd_addr_q, in_rd_addr_d;
    logic [IN_W-1:0]       dp_data_q, dp_data_d;
    logic                  dp_valid_q, dp_valid_d;
    logic [SEL_W-1:0]      dp_sel_q, dp_sel_d;
    logic                  wr_en_q, wr_en_d;
    logic [AW-1:0]         wr_addr_q, wr_addr_d;
    logic [c_PACK_W-1:0]   wr_data_q, wr_data_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic                  err_q, err_d;

    logic                  w_parked;
    logic                  w_start_acc;
    logic                  w_accept;
    logic                  w_spurious;

    // Capture is live in every state except IDLE/DONE. A result is only
    // legal when at least one issued beat is still unanswered; outst_q
    // counts beats issued in earlier cycles that have not yet returned.
    assign w_parked    = (state_q == ST_IDLE) || (state_q == ST_DONE);
    assign w_start_acc = start_i && w_parked;
    assign w_accept    = dp_data_out_valid_i && !w_parked && (outst_q != '0);
    assign w_spurious  = dp_data_out_valid_i && !w_accept;

    always_comb begin
        state_d      = state_q;
        tok_d        = tok_q;
        beat_d       = beat_q;
        hold_d       = hold_q;
        cap_tok_d    = cap_tok_q;
        cap_blk_d    = cap_blk_q;
        pack_d       = pack_q;
        outst_d      = outst_q;
        busy_d       = busy_q;
        done_d       = done_q;
        err_d        = err_q;
        in_rd_en_d   = 1'b0;
        in_rd_addr_d = '0;
        dp_valid_d   = 1'b0;
        dp_sel_d     = '0;
        dp_data_d    = '0;
        wr_en_d      = 1'b0;
        wr_addr_d    = '0;
        wr_data_d    = '0;

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (w_start_acc) begin
                    state_d   = ST_FETCH;
                    tok_d     = '0;
                    cap_tok_d = '0;
                    cap_blk_d = '0;
                    outst_d   = '0;
                    busy_d    = 1'b1;
                    done_d    = 1'b0;
                    err_d     = 1'b0;
                end
            end
            ST_FETCH: begin
                state_d = ST_LOAD;
            end
            ST_LOAD: begin
                hold_d  = in_rd_data_i;
                beat_d  = '0;
                state_d = ST_ISSUE;
            end
            ST_ISSUE: begin
                if (beat_q == c_LAST_BLK) begin
                    if (tok_q == c_LAST_TOK) begin
                        state_d = ST_DRAIN;
                    end else begin
                        tok_d   = tok_q + AW'(1);
                        state_d = ST_FETCH;
                    end
                end else begin
                    beat_d = beat_q + SEL_W'(1);
                end
            end
            ST_DRAIN: begin
                // The final word is on the write port this cycle.
                if (wr_en_q && (wr_addr_q == c_LAST_TOK)) begin
                    state_d = ST_DONE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Outstanding-beat bookkeeping: beats on the issue port this cycle
        // become outstanding from the next cycle onward.
        if (dp_valid_q) begin
            outst_d = outst_d + c_OUTS_W'(1);
        end
        if (w_accept) begin
            outst_d = outst_d - c_OUTS_W'(1);
        end

        if (w_spurious) begin
            err_d = 1'b1;
        end

        // Result capture and packing; the word is written the cycle after
        // its last block arrives.
        if (w_accept) begin
            for (int b = 0; b < NUM_BLOCKS; b++) begin
                if (cap_blk_q == SEL_W'(b)) begin
                    pack_d[b*OUT_W +: OUT_W] = dp_data_out_i;
                end
            end
            if (cap_blk_q == c_LAST_BLK) begin
                wr_en_d   = 1'b1;
                wr_addr_d = cap_tok_q;
                wr_data_d = pack_d;
                cap_blk_d = '0;
                if (cap_tok_q != c_LAST_TOK) begin
                    cap_tok_d = cap_tok_q + AW'(1);
                end
            end else begin
                cap_blk_d = cap_blk_q + SEL_W'(1);
            end
        end

        // Outputs are registered from the upcoming state so each strobe
        // coincides with the cycle spent in the corresponding state.
        if (state_d == ST_FETCH) begin
            in_rd_en_d   = 1'b1;
            in_rd_addr_d = tok_d;
        end
        if (state_d == ST_ISSUE) begin
            dp_valid_d = 1'b1;
            dp_sel_d   = beat_d;
            dp_data_d  = hold_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            tok_q        <= '0;
            beat_q       <= '0;
            hold_q       <= '0;
            cap_tok_q    <= '0;
            cap_blk_q    <= '0;
            pack_q       <= '0;
            outst_q      <= '0;
            in_rd_en_q   <= 1'b0;
            in_rd_addr_q <= '0;
            dp_data_q    <= '0;
            dp_valid_q   <= 1'b0;
            dp_sel_q     <= '0;
            wr_en_q      <= 1'b0;
            wr_addr_q    <= '0;
            wr_data_q    <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            tok_q        <= tok_d;
            beat_q       <= beat_d;
            hold_q       <= hold_d;
            cap_tok_q    <= cap_tok_d;
            cap_blk_q    <= cap_blk_d;
            pack_q       <= pack_d;
            outst_q      <= outst_d;
            in_rd_en_q   <= in_rd_en_d;
            in_rd_addr_q <= in_rd_addr_d;
            dp_data_q    <= dp_data_d;
            dp_valid_q   <= dp_valid_d;
            dp_sel_q     <= dp_sel_d;
            wr_en_q      <= wr_en_d;
            wr_addr_q    <= wr_addr_d;
            wr_data_q    <= wr_data_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            err_q        <= err_d;
        end
    end

    assign in_rd_en_o         = in_rd_en_q;
    assign in_rd_addr_o       = in_rd_addr_q;
    assign dp_data_in_o       = dp_data_q;
    assign dp_data_in_valid_o = dp_valid_q;
    assign dp_block_sel_o     = dp_sel_q;
    assign out_wr_en_o        = wr_en_q;
    assign out_wr_addr_o      = wr_addr_q;
    assign out_wr_data_o      = wr_data_q;
    assign busy_o             = busy_q;
    assign done_o             = done_q;
    assign err_o              = err_q;

endmodule
`default_nettype wire

// File: tb/tb_binary_intermediate_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_binary_intermediate_ctrl
// Description : Self-checking bench for binary_intermediate_ctrl. A token
//               buffer model and an in-order variable-latency datapath model
//               surround the DUT; every run is compared against the expected
//               packed words computed straight from the token memory.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_binary_intermediate_ctrl;

    localparam int NT = 30;
    localparam int NB = 4;

    logic        clk                 = 1'b0;
    logic        rst_n               = 1'b0;
    logic        start_i             = 1'b0;
    logic        in_rd_en_o;
    logic [4:0]  in_rd_addr_o;
    logic [63:0] in_rd_data_i        = '0;
    logic [63:0] dp_data_in_o;
    logic        dp_data_in_valid_o;
    logic [1:0]  dp_block_sel_o;
    logic [15:0] dp_data_out_i       = '0;
    logic        dp_data_out_valid_i = 1'b0;
    logic        out_wr_en_o;
    logic [4:0]  out_wr_addr_o;
    logic [63:0] out_wr_data_o;
    logic        busy_o;
    logic        done_o;
    logic        err_o;

    int checks = 0;
    int errors = 0;

    binary_intermediate_ctrl dut (
        .clk                 (clk),
        .rst_n               (rst_n),
        .start_i             (start_i),
        .in_rd_en_o          (in_rd_en_o),
        .in_rd_addr_o        (in_rd_addr_o),
        .in_rd_data_i        (in_rd_data_i),
        .dp_data_in_o        (dp_data_in_o),
        .dp_data_in_valid_o  (dp_data_in_valid_o),
        .dp_block_sel_o      (dp_block_sel_o),
        .dp_data_out_i       (dp_data_out_i),
        .dp_data_out_valid_i (dp_data_out_valid_i),
        .out_wr_en_o         (out_wr_en_o),
        .out_wr_addr_o       (out_wr_addr_o),
        .out_wr_data_o       (out_wr_data_o),
        .busy_o              (busy_o),
        .done_o              (done_o),
        .err_o               (err_o)
    );

    always #5 clk = ~clk;

    // ---------------- environment state ----------------
    logic [63:0] mem [NT];
    logic [63:0] wgt [NB];
    int          lat      = 1;
    int          jit      = 0;
    bit          inj_now  = 1'b0;
    bit          inj_mid  = 1'b0;
    int          n_inj    = 0;
    int          cyc      = 0;
    bit          pend_rd  = 1'b0;
    logic [4:0]  pend_addr = '0;
    logic [15:0] dq_val [$];
    int          dq_due [$];
    int          last_due = 0;

    logic [4:0]  rd_log      [$];
    logic [1:0]  iss_sel     [$];
    logic [63:0] iss_dat     [$];
    logic [4:0]  wr_addr_log [$];
    logic [63:0] wr_data_log [$];
    int          wr_cyc_log  [$];
    int          first_rd  = -1;
    int          last_iss  = -1;
    int          done_cyc  = -1;
    int          n_iss     = 0;
    bit          done_prev = 1'b0;

    // Reference datapath: XNOR-popcount against a per-block weight, with the
    // block index tagged in the top nibble so every block result differs.
    function automatic logic [15:0] ref_fn(input logic [63:0] d, input int s);
        logic [63:0] x;
        int          pc;
        x  = ~(d ^ wgt[s]);
        pc = 0;
        for (int i = 0; i < 64; i++) pc += int'(x[i]);
        return 16'(s * 4096 + pc);
    endfunction

    function automatic logic [63:0] exp_word(input int t);
        logic [63:0] w;
        w = '0;
        for (int b = 0; b < NB; b++) w[b*16 +: 16] = ref_fn(mem[t], b);
        return w;
    endfunction

    function automatic logic [255:0] outs_vec();
        return 256'({in_rd_en_o, in_rd_addr_o, dp_data_in_o, dp_data_in_valid_o,
                     dp_block_sel_o, out_wr_en_o, out_wr_addr_o, out_wr_data_o,
                     busy_o, done_o, err_o});
    endfunction

    // Token buffer, datapath model and monitor, all acting 1 time unit after
    // each rising edge so DUT outputs for the current cycle are settled.
    initial begin
        int due;
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            if (!rst_n) begin
                pend_rd             = 1'b0;
                dq_val.delete();
                dq_due.delete();
                last_due            = 0;
                dp_data_out_valid_i = 1'b0;
                in_rd_data_i        = {$urandom, $urandom};
            end else begin
                in_rd_data_i = pend_rd ? mem[pend_addr] : {$urandom, $urandom};
                pend_rd      = in_rd_en_o;
                pend_addr    = in_rd_addr_o;

                dp_data_out_valid_i = 1'b0;
                dp_data_out_i       = 16'($urandom);
                if (dq_due.size() > 0 && dq_due[0] == cyc) begin
                    dp_data_out_valid_i = 1'b1;
                    dp_data_out_i       = dq_val.pop_front();
                    void'(dq_due.pop_front());
                end else if (inj_now || (inj_mid && dq_due.size() == 0 && busy_o && n_iss >= 8)) begin
                    dp_data_out_valid_i = 1'b1;
                    dp_data_out_i       = 16'hBEEF;
                    inj_now             = 1'b0;
                    inj_mid             = 1'b0;
                    n_inj++;
                end
                if (dp_data_in_valid_o) begin
                    due = cyc + lat + int'($urandom_range(0, jit));
                    if (due <= last_due) due = last_due + 1;
                    last_due = due;
                    dq_due.push_back(due);
                    dq_val.push_back(ref_fn(dp_data_in_o, int'(dp_block_sel_o)));
                end
            end
            if (in_rd_en_o) begin
                rd_log.push_back(in_rd_addr_o);
                if (first_rd < 0) first_rd = cyc;
            end
            if (dp_data_in_valid_o) begin
                iss_sel.push_back(dp_block_sel_o);
                iss_dat.push_back(dp_data_in_o);
                last_iss = cyc;
                n_iss++;
            end
            if (out_wr_en_o) begin
                wr_addr_log.push_back(out_wr_addr_o);
                wr_data_log.push_back(out_wr_data_o);
                wr_cyc_log.push_back(cyc);
            end
            if (done_o && !done_prev) done_cyc = cyc;
            done_prev = done_o;
        end
    end

    // ---------------- checking helpers ----------------
    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clear_logs();
        rd_log.delete();
        iss_sel.delete();
        iss_dat.delete();
        wr_addr_log.delete();
        wr_data_log.delete();
        wr_cyc_log.delete();
        first_rd = -1;
        last_iss = -1;
        done_cyc = -1;
        n_iss    = 0;
    endtask

    task automatic fill_nominal();
        logic [4:0] tv;
        for (int t = 0; t < NT; t++) begin
            tv     = 5'(t);
            mem[t] = {16{tv[3:0]}};
        end
    endtask

    task automatic fill_random();
        for (int t = 0; t < NT; t++) mem[t] = {$urandom, $urandom};
    endtask

    // Called on a falling edge; start is sampled on the next rising edge.
    task automatic pulse_start(input string tag);
        start_i = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
        check({tag, " busy_after_start"}, 256'(busy_o), 256'(1));
        check({tag, " done_cleared"}, 256'(done_o), 256'(0));
    endtask

    task automatic wait_done(input string tag);
        int k;
        k = 0;
        while (done_o !== 1'b1 && k < 2000) begin
            @(negedge clk);
            k++;
        end
        check({tag, " done_reached"}, 256'(done_o), 256'(1));
    endtask

    task automatic wait_iss(input int n);
        int k;
        k = 0;
        while (n_iss < n && k < 1000) begin
            @(negedge clk);
            k++;
        end
        check("issue_count_reached", 256'(n_iss >= n), 256'(1));
    endtask

    task automatic wait_wr(input int n);
        int k;
        k = 0;
        while (wr_addr_log.size() < n && k < 1000) begin
            @(negedge clk);
            k++;
        end
        check("write_count_reached", 256'(wr_addr_log.size() >= n), 256'(1));
    endtask

    task automatic check_run(input string tag);
        int bad;
        int exp_done;
        check({tag, " write_count"}, 256'(wr_addr_log.size()), 256'(NT));
        for (int i = 0; i < wr_addr_log.size() && i < NT; i++)
            check({tag, " write"}, 256'({wr_addr_log[i], wr_data_log[i]}),
                  256'({5'(i), exp_word(i)}));
        check({tag, " issue_count"}, 256'(iss_sel.size()), 256'(NT * NB));
        bad = 0;
        for (int i = 0; i < iss_sel.size() && i < NT * NB; i++)
            if (iss_sel[i] !== 2'(i % NB) || iss_dat[i] !== mem[i / NB]) bad++;
        check({tag, " issue_beats_bad"}, 256'(bad), 256'(0));
        check({tag, " read_count"}, 256'(rd_log.size()), 256'(NT));
        bad = 0;
        for (int i = 0; i < rd_log.size(); i++)
            if (rd_log[i] !== 5'(i)) bad++;
        check({tag, " read_order_bad"}, 256'(bad), 256'(0));
        check({tag, " issue_span"}, 256'(last_iss - first_rd + 1), 256'(NT * 6));
        exp_done = (wr_cyc_log.size() > 0) ? wr_cyc_log[wr_cyc_log.size() - 1] + 1 : -5;
        check({tag, " done_timing"}, 256'(done_cyc), 256'(exp_done));
        check({tag, " busy_at_done"}, 256'(busy_o), 256'(0));
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        for (int w = 0; w < NB; w++) wgt[w] = {$urandom, $urandom};
        fill_nominal();
        repeat (3) @(negedge clk);
        check("reset_outputs", outs_vec(), 256'(0));
        rst_n = 1'b1;
        @(negedge clk);
        check("idle_outputs", outs_vec(), 256'(0));

        // Nominal run, 1-cycle datapath.
        lat = 1; jit = 0;
        clear_logs();
        pulse_start("nominal");
        wait_done("nominal");
        check_run("nominal");
        check("nominal err", 256'(err_o), 256'(0));

        // Back-to-back: start in the first DONE cycle, variable latency,
        // same token memory so the written words must repeat exactly.
        lat = 3; jit = 2;
        clear_logs();
        pulse_start("varlat");
        wait_done("varlat");
        check_run("varlat");
        check("varlat err", 256'(err_o), 256'(0));

        repeat (3) @(negedge clk);
        check("done_held", 256'(done_o), 256'(1));

        // Start pulses while busy must be ignored.
        fill_random();
        lat = 2; jit = 1;
        clear_logs();
        pulse_start("busy_start");
        wait_iss(10);
        start_i = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
        wait_iss(100);
        start_i = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
        wait_done("busy_start");
        check_run("busy_start");

        // Reset mid-run after the write to address 12.
        fill_random();
        lat = 1; jit = 0;
        clear_logs();
        pulse_start("reset_run");
        wait_wr(13);
        #1;
        rst_n = 1'b0;
        #1;
        check("async_reset_outputs", outs_vec(), 256'(0));
        repeat (3) @(negedge clk);
        check("writes_during_reset", 256'(wr_addr_log.size()), 256'(13));
        check("outputs_in_reset", outs_vec(), 256'(0));
        rst_n = 1'b1;
        @(negedge clk);
        check("idle_after_reset", outs_vec(), 256'(0));

        // Spurious result while idle.
        clear_logs();
        n_inj   = 0;
        inj_now = 1'b1;
        repeat (2) @(negedge clk);
        check("err_idle", 256'(err_o), 256'(1));
        check("no_write_idle", 256'(wr_addr_log.size()), 256'(0));

        // Fresh run clears err; a spurious mid-run result sets it again.
        fill_random();
        clear_logs();
        pulse_start("after_reset");
        check("err_cleared_by_start", 256'(err_o), 256'(0));
        inj_mid = 1'b1;
        wait_done("after_reset");
        check_run("after_reset");
        check("spurious_injected", 256'(n_inj), 256'(2));
        check("err_sticky", 256'(err_o), 256'(1));

        // Next start clears err again and the run is clean.
        clear_logs();
        pulse_start("final");
        check("err_cleared_final", 256'(err_o), 256'(0));
        wait_done("final");
        check_run("final");
        check("final err", 256'(err_o), 256'(0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
